// File: rtl/norm_shift.sv
// norm_shift: multi-cycle normalization shifter for the FP adder.
// One binary-halving shift stage (16,8,4,2,1) is applied per clock.
module norm_shift #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [CNT_W-1:0]  lz_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero_out,
  output logic              denorm_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int AW = (EXP_W > CNT_W) ? EXP_W : CNT_W;
  localparam logic [CNT_W-1:0] LZ_MAX = CNT_W'(MANT_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]  amt_q, amt_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              zero_q, zero_d;
  logic              denorm_q, denorm_d;

  logic [CNT_W-1:0]  lz;
  logic [AW-1:0]     lz_w;
  logic [AW-1:0]     exp_w;
  logic [CNT_W-1:0]  sh;
  logic              m_zero;

  assign lz     = (lz_in > LZ_MAX) ? LZ_MAX : lz_in;
  assign lz_w   = AW'(lz);
  assign exp_w  = AW'(exp_in);
  assign m_zero = (mant_in == '0);
  // amt bit for this step, already weighted: either 0 or 2^step
  assign sh     = amt_q & (CNT_W'(1) << step_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    amt_d    = amt_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          step_d  = CNT_W'(CNT_W - 1);
          mant_d  = mant_in;
          zero_d  = 1'b0;
          unique case (1'b1)
            m_zero: begin
              amt_d    = '0;
              exp_d    = '0;
              zero_d   = 1'b1;
              denorm_d = 1'b0;
            end
            (!m_zero && exp_w > lz_w): begin
              amt_d    = lz;
              exp_d    = exp_in - EXP_W'(lz);
              denorm_d = 1'b0;
            end
            (!m_zero && exp_w <= lz_w && exp_in != '0): begin
              amt_d    = CNT_W'(exp_in - EXP_W'(1));
              exp_d    = '0;
              denorm_d = 1'b1;
            end
            default: begin
              amt_d    = '0;
              exp_d    = '0;
              denorm_d = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        mant_d = mant_q << sh;
        if (step_q == '0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      amt_q    <= '0;
      mant_q   <= '0;
      exp_q    <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      amt_q    <= amt_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !reset;
  assign out_valid  = (state_q == DONE);
  assign mant_out   = mant_q;
  assign exp_out    = exp_q;
  assign zero_out   = zero_q;
  assign denorm_out = denorm_q;

endmodule
